// File: rtl/l1i_fetch_responder.sv
// Direct-mapped L1 instruction-cache responder: serves 64-byte line fetches,
// fills misses from the next level one at a time, and honours frontend kills.
module l1i_fetch_responder #(
  parameter int unsigned SETS            = 16,
  parameter int unsigned LINE_SIZE_BYTES = 64,
  parameter int unsigned PC_SIZE         = 64
) (
  input  logic                         clk_in,
  input  logic                         rst_N_in,
  input  logic                         bp_req_valid,
  input  logic [PC_SIZE-1:0]           bp_req_addr,
  input  logic                         bp_kill,
  input  logic                         inv_all,
  output logic                         l1i_ready,
  output logic                         l1i_valid,
  output logic [PC_SIZE-1:0]           l1i_resp_addr,
  output logic [8*LINE_SIZE_BYTES-1:0] l1i_cacheline,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [PC_SIZE-1:0]           mem_req_addr,
  input  logic                         mem_resp_valid,
  input  logic [8*LINE_SIZE_BYTES-1:0] mem_resp_data
);

  localparam int unsigned LINE_W = 8 * LINE_SIZE_BYTES;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = PC_SIZE - OFF_W - IDX_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    RESPOND  = 3'd2,
    MEM_REQ  = 3'd3,
    MEM_WAIT = 3'd4
  } state_t;

  state_t                state;
  logic [PC_SIZE-1:0]    req_addr;
  logic                  killed;
  logic [SETS-1:0]       line_valid;
  logic [TAG_W-1:0]      tag_mem  [SETS];
  logic [LINE_W-1:0]     data_mem [SETS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  kill_now;
  logic                  hit;
  logic                  fill_we;
  logic                  unused_offset;

  assign idx      = req_addr[OFF_W +: IDX_W];
  assign tag      = req_addr[PC_SIZE-1 : OFF_W+IDX_W];
  assign kill_now = killed | bp_kill;
  // A same-cycle invalidate wins over the lookup so the stale line is never served.
  assign hit      = line_valid[idx] && (tag_mem[idx] == tag) && !inv_all;
  assign fill_we  = (state == MEM_WAIT) && mem_resp_valid;

  assign l1i_ready     = (state == IDLE) && rst_N_in;
  // A kill arriving in RESPOND still suppresses that cycle's pulse.
  assign l1i_valid     = (state == RESPOND) && !kill_now;
  assign mem_req_valid = (state == MEM_REQ);
  assign unused_offset = &{1'b0, bp_req_addr[OFF_W-1:0]};

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state         <= IDLE;
      req_addr      <= '0;
      killed        <= 1'b0;
      line_valid    <= '0;
      l1i_resp_addr <= '0;
      l1i_cacheline <= '0;
      mem_req_addr  <= '0;
    end else begin
      // Invalidate first so a coincident fill leaves its own line valid.
      if (inv_all) line_valid <= '0;
      if (fill_we) line_valid[idx] <= 1'b1;
      if (state != IDLE && bp_kill) killed <= 1'b1;

      case (state)
        IDLE: begin
          killed <= 1'b0;
          if (bp_req_valid) begin
            req_addr <= {bp_req_addr[PC_SIZE-1:OFF_W], OFF_W'(0)};
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (kill_now) begin
              state <= IDLE;
            end else begin
              l1i_cacheline <= data_mem[idx];
              l1i_resp_addr <= req_addr;
              state         <= RESPOND;
            end
          end else begin
            mem_req_addr <= req_addr;
            state        <= MEM_REQ;
          end
        end
        RESPOND: state <= IDLE;
        MEM_REQ: begin
          if (mem_req_ready) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_resp_valid) begin
            if (kill_now) begin
              state <= IDLE;
            end else begin
              l1i_cacheline <= mem_resp_data;
              l1i_resp_addr <= req_addr;
              state         <= RESPOND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_l1i_fetch_responder.sv
// Scoreboard bench for l1i_fetch_responder: a small cache model predicts hit/miss,
// expected responses are queued at stimulus time and popped when l1i_valid pulses.
module tb_l1i_fetch_responder;

  logic         clk_in = 1'b0;
  logic         rst_N_in;
  logic         bp_req_valid;
  logic [63:0]  bp_req_addr;
  logic         bp_kill;
  logic         inv_all;
  logic         l1i_ready;
  logic         l1i_valid;
  logic [63:0]  l1i_resp_addr;
  logic [511:0] l1i_cacheline;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [63:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [511:0] mem_resp_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0]  q_addr[$];
  logic [511:0] q_line[$];

  bit           m_valid[16];
  logic [63:0]  m_addr[16];
  logic [511:0] m_data[16];

  l1i_fetch_responder #(.SETS(16), .LINE_SIZE_BYTES(64), .PC_SIZE(64)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .bp_req_valid(bp_req_valid), .bp_req_addr(bp_req_addr),
    .bp_kill(bp_kill), .inv_all(inv_all),
    .l1i_ready(l1i_ready), .l1i_valid(l1i_valid),
    .l1i_resp_addr(l1i_resp_addr), .l1i_cacheline(l1i_cacheline),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] line_of(input int seed);
    logic [511:0] l;
    for (int i = 0; i < 64; i++) l[i*8 +: 8] = 8'(i + seed);
    return l;
  endfunction

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (rst_N_in === 1'b1 && l1i_valid === 1'b1) begin
      if (q_addr.size() == 0) begin
        check("unexpected_valid", 1'b1, 1'b0);
      end else begin
        check("resp_addr", l1i_resp_addr, q_addr.pop_front());
        check("resp_line", l1i_cacheline, q_line.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk_in);
    while (l1i_ready !== 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (l1i_ready !== 1'b1) check("ready_timeout", l1i_ready, 1'b1);
  endtask

  // One fetch; miss path handshakes with the bench memory model.
  task automatic fetch(input logic [63:0] a, input int seed, input int stall,
                       input bit kill_wait, input bit inv_fill, input bit kill_idle);
    logic [63:0] al;
    int idx;
    bit exp_hit;
    al = {a[63:6], 6'd0};
    idx = int'(a[9:6]);
    exp_hit = m_valid[idx] && (m_addr[idx] == al);
    wait_ready();
    @(posedge clk_in); #1;
    bp_req_valid = 1'b1; bp_req_addr = a; bp_kill = kill_idle;
    if (exp_hit) begin
      q_addr.push_back(al);
      q_line.push_back(m_data[idx]);
    end
    @(posedge clk_in); #1;
    bp_req_valid = 1'b0; bp_kill = 1'b0;
    @(negedge clk_in);
    check("t1_valid_early", l1i_valid, 1'b0);
    @(negedge clk_in);
    if (exp_hit) begin
      check("hit_valid_t2", l1i_valid, 1'b1);
      check("hit_no_mem", mem_req_valid, 1'b0);
    end else begin
      check("miss_req_valid_t2", mem_req_valid, 1'b1);
      check("miss_req_addr", mem_req_addr, al);
      check("miss_no_valid", l1i_valid, 1'b0);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk_in);
        check("stall_req_valid", mem_req_valid, 1'b1);
        check("stall_req_addr", mem_req_addr, al);
      end
      @(posedge clk_in); #1 mem_req_ready = 1'b1;
      @(posedge clk_in); #1 mem_req_ready = 1'b0;
      @(negedge clk_in);
      check("req_dropped", mem_req_valid, 1'b0);
      if (kill_wait) begin
        @(posedge clk_in); #1 bp_kill = 1'b1;
        @(posedge clk_in); #1 bp_kill = 1'b0;
      end
      @(posedge clk_in); #1;
      mem_resp_valid = 1'b1; mem_resp_data = line_of(seed); inv_all = inv_fill;
      if (!kill_wait) begin
        q_addr.push_back(al);
        q_line.push_back(line_of(seed));
      end
      if (inv_fill) for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
      m_valid[idx] = 1'b1; m_addr[idx] = al; m_data[idx] = line_of(seed);
      @(posedge clk_in); #1;
      mem_resp_valid = 1'b0; inv_all = 1'b0;
      @(negedge clk_in);
      check("fill_resp_valid", l1i_valid, !kill_wait);
    end
    @(negedge clk_in);
    check("single_pulse", l1i_valid, 1'b0);
  endtask

  task automatic invalidate();
    @(posedge clk_in); #1 inv_all = 1'b1;
    @(posedge clk_in); #1 inv_all = 1'b0;
    for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=%0d exp=0", 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_N_in = 1'b0; bp_req_valid = 1'b0; bp_req_addr = '0; bp_kill = 1'b0;
    inv_all = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_valid", l1i_valid, 1'b0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_ready", l1i_ready, 1'b0);
    check("rst_resp_addr", l1i_resp_addr, 64'd0);
    check("rst_mem_addr", mem_req_addr, 64'd0);
    check("rst_line", l1i_cacheline, 512'd0);
    @(posedge clk_in); #1 rst_N_in = 1'b1;

    // cold miss, then hit within the same line
    fetch(64'h1048, 0, 0, 0, 0, 0);
    check("t1_byte8", l1i_cacheline[71:64], 8'h08);
    check("t1_hold_addr", l1i_resp_addr, 64'h1040);
    fetch(64'h107C, 0, 0, 0, 0, 0);
    // backpressure
    fetch(64'h3000, 9, 5, 0, 0, 0);
    // kill in MEM_WAIT: fill lands silently, then hits
    fetch(64'h5123, 21, 1, 1, 0, 0);
    fetch(64'h5100, 0, 0, 0, 0, 0);
    // kill in IDLE with a simultaneous accept has no effect
    fetch(64'h3010, 0, 0, 0, 0, 1);
    // conflict eviction on index 0
    fetch(64'h0000, 3, 0, 0, 0, 0);
    fetch(64'h0400, 5, 0, 0, 0, 0);
    fetch(64'h0000, 7, 0, 0, 0, 0);
    // invalidate, then invalidate coincident with a fill
    invalidate();
    fetch(64'h1048, 11, 0, 0, 0, 0);
    fetch(64'h2080, 13, 0, 0, 1, 0);
    fetch(64'h20BF, 0, 0, 0, 0, 0);
    fetch(64'h1040, 0, 0, 0, 0, 0);

    // reset in MEM_REQ, stray fill in IDLE
    wait_ready();
    @(posedge clk_in); #1 bp_req_valid = 1'b1; bp_req_addr = 64'h7040;
    @(posedge clk_in); #1 bp_req_valid = 1'b0;
    @(negedge clk_in); @(negedge clk_in);
    check("pre_rst_req", mem_req_valid, 1'b1);
    @(posedge clk_in); #1 rst_N_in = 1'b0;
    #1;
    check("rst_drop_req", mem_req_valid, 1'b0);
    check("rst_drop_ready", l1i_ready, 1'b0);
    check("rst_drop_line", l1i_cacheline, 512'd0);
    for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
    @(posedge clk_in); #1 rst_N_in = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = line_of(99);
    @(posedge clk_in); #1 mem_resp_valid = 1'b0;
    @(negedge clk_in);
    check("stray_fill_no_valid", l1i_valid, 1'b0);
    @(negedge clk_in);
    check("stray_fill_no_valid2", l1i_valid, 1'b0);
    fetch(64'h7040, 31, 0, 0, 0, 0);

    repeat (3) @(negedge clk_in);
    check("sb_empty", 32'(q_addr.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/l1i_fetch_responder.md
Name: l1i_fetch_responder

Overview:
L1 instruction-cache responder. It serves line-fetch requests from the branch predictor / fetch frontend and returns one 64-byte cacheline per request through a one-cycle valid pulse. The array is a direct-mapped tag/data store. Misses are filled from the next memory level, with one outstanding request at a time. A kill input lets the frontend discard an in-flight request after a redirect, so the stale line is never presented.

Parameters:
SETS, 16, number of direct-mapped lines (power of two, >=2)
LINE_SIZE_BYTES, 64, bytes per line; fixed at 64 (offset addr[5:0])
PC_SIZE, 64, address width

Ports:
clk_in  input  1  clock, rising edge
rst_N_in  input  1  reset, asynchronous, active-low
bp_req_valid  input  1  frontend presents a fetch address
bp_req_addr  input  PC_SIZE  fetch byte address (any alignment)
bp_kill  input  1  discard the currently outstanding request
inv_all  input  1  invalidate every line
l1i_ready  output  1  block can accept a request this cycle
l1i_valid  output  1  one-cycle pulse: l1i_cacheline / l1i_resp_addr valid
l1i_resp_addr  output  PC_SIZE  line-aligned address of returned line
l1i_cacheline  output  8 x LINE_SIZE_BYTES  returned line, byte i = addr offset i
mem_req_valid  output  1  miss request to next level
mem_req_ready  input  1  next level accepts request
mem_req_addr  output  PC_SIZE  line-aligned miss address
mem_resp_valid  input  1  fill data valid (one cycle)
mem_resp_data  input  8 x LINE_SIZE_BYTES  fill line

Behaviour:
- Address split:
  - index = addr[6+log2(SETS)-1:6]
  - tag = addr[PC_SIZE-1:6+log2(SETS)]
  - resp/mem addresses = request addr with [5:0] cleared.
- Reset while rst_N_in is low:
  - state IDLE; all line valid bits 0; killed flag 0.
  - l1i_valid=0, mem_req_valid=0, l1i_ready=0.
  - l1i_resp_addr, mem_req_addr and l1i_cacheline are all zero.
- Reset mid-operation abandons the transaction. mem_resp_valid is sampled only in MEM_WAIT, so a late fill arriving in IDLE is ignored.
- l1i_ready = (state==IDLE) && rst_N_in. A request is accepted at an edge where bp_req_valid && l1i_ready; the address is latched.
- States:
  - IDLE: on accept -> LOOKUP.
  - LOOKUP: reads tag/valid of latched index.
    - Hit and not killed -> RESPOND, with line data registered.
    - Hit and killed -> IDLE.
    - Miss -> MEM_REQ, regardless of kill.
  - RESPOND: l1i_valid=1 for exactly this cycle -> IDLE.
  - MEM_REQ: mem_req_valid=1 and mem_req_addr held stable until the edge with mem_req_ready=1 -> MEM_WAIT.
  - MEM_WAIT: on the mem_resp_valid edge, write data/tag/valid into the indexed line.
    - Not killed -> RESPOND, l1i_cacheline = mem_resp_data.
    - Killed -> IDLE.
- Latency:
  - Hit accepted at edge T: l1i_valid high in cycle T+2.
  - Miss: mem_req_valid first high in cycle T+2; l1i_valid high in the cycle after the mem_resp_valid edge.
- Kill handling:
  - bp_kill in any non-IDLE state sets killed. The memory transaction is never cancelled; the fill is still written; only l1i_valid is suppressed.
  - bp_kill in IDLE has no effect, even with a simultaneous request accept.
  - killed clears on return to IDLE.
  - bp_kill in RESPOND suppresses that cycle's l1i_valid.
- l1i_cacheline and l1i_resp_addr hold their last response value between pulses.
- inv_all:
  - Clears all valid bits at the edge.
  - In LOOKUP, inv_all forces a miss.
  - If it coincides with a fill write, the invalidate applies first and the fill line ends valid.
- A miss to an occupied set evicts unconditionally (no write-back: instruction cache).

Test Plan:
1. Cold miss: req 0x1048 -> mem_req_addr=0x1040 at T+2. With mem_req_ready=1 and fill of bytes i=i, l1i_valid next cycle: resp_addr=0x1040, byte 8=0x08.
2. Hit after fill: req 0x107C -> l1i_valid at T+2, same line, no mem_req_valid.
3. Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and mem_req_addr stable 5 cycles. The transfer happens on the first ready edge.
4. Kill during MEM_WAIT: fill arrives -> no l1i_valid. A following req to the same line hits with no memory request.
5. Conflict eviction (SETS=16): fill 0x0000, then 0x0400 (same index 0) -> the 0x0000 request misses again.
6. inv_all after fill, then same address -> miss. inv_all coincident with fill -> following req hits. Reset asserted in MEM_REQ -> mem_req_valid drops immediately; a stray mem_resp_valid in IDLE produces no l1i_valid.
